cpu_vector_checker: RTL and testbench
=====================================

// Module: cpu_vector_checker
// PURPOSE
//  Synthesizable, parametrised vector player/checker for the microsequenced CPU: replaces ad-hoc bench tasks.
//  Stores up to DEPTH (stimulus, expected, mask) vectors and issues a CPU reset pulse.
//  Drives one stimulus word per cycle onto the CPU data input and compares the CPU data output under mask.
//  Waits for the microsequencer to return to CAR==0, then reports pass/fail counts and first-failure details.
// PARAMETERS
//  DATA_W   16   CPU data word width
//  DEPTH    16   max vectors stored
//  IDX_W    $clog2(DEPTH)   vector index width
//  CNT_W    16   pass/fail counter width (saturating)
//  TIMEOUT  255  max DRAIN cycles waiting for CAR_ZERO
// PORTS
//  CLK         in   1        clock
//  RST         in   1        synchronous, active-low reset
//  LOAD_EN     in   1        write vector LOAD_IDX (ignored unless IDLE)
//  LOAD_IDX    in   IDX_W    vector slot
//  LOAD_STIM   in   DATA_W   stimulus word
//  LOAD_EXP    in   DATA_W   expected CPU output
//  LOAD_MASK   in   DATA_W   compare mask (1 = bit checked)
//  NUM_VEC     in   IDX_W+1  vectors to run, sampled at START
//  START       in   1        begin run (ignored unless IDLE)
//  CAR_ZERO    in   1        CPU control address register == 0
//  DATA_O_CPU  in   DATA_W   CPU data output under test
//  DATA_I_CPU  out  DATA_W   stimulus to CPU data input (registered)
//  CPU_RST_N   out  1        reset to CPU, active-low
//  BUSY        out  1        run in progress
//  DONE        out  1        one-cycle pulse at end of run
//  PASS        out  1        FAIL_CNT==0 && !TIMEOUT_ERR; held until next START
//  PASS_CNT    out  CNT_W    vectors matched
//  FAIL_CNT    out  CNT_W    vectors mismatched
//  FF_VALID    out  1        first-failure fields valid
//  FF_IDX      out  IDX_W    index of first failing vector
//  FF_GOT      out  DATA_W   DATA_O_CPU captured at first failure
//  TIMEOUT_ERR out  1        DRAIN exceeded TIMEOUT
// BEHAVIOUR
//  Reset (RST==0 at posedge): state IDLE; DATA_I_CPU=0, CPU_RST_N=1, BUSY=0, DONE=0, PASS=0, counters=0,
//   FF_*=0, TIMEOUT_ERR=0; vector store NOT cleared. Reset mid-run aborts immediately, no DONE.
//  States: IDLE -> RSTP -> WARM -> RUN -> DRAIN -> REPORT -> IDLE.
//  IDLE: START=1 clears counters/FF_*/TIMEOUT_ERR/PASS, latches NUM_VEC, -> RSTP; BUSY=1 from next cycle.
//  RSTP: CPU_RST_N=0 for exactly 1 cycle. WARM: CPU_RST_N=1, 2 cycles.
//  RUN: idx 0..NUM_VEC-1; DATA_I_CPU<=STIM[idx] at edge entering cycle; at the following edge
//   compare (DATA_O_CPU & MASK[idx]) vs (EXP[idx] & MASK[idx]); match -> PASS_CNT++, else FAIL_CNT++;
//   first mismatch only sets FF_VALID/FF_IDX/FF_GOT. One vector per cycle, no gaps.
//  NUM_VEC==0: WARM -> DRAIN directly; NUM_VEC>DEPTH clamped to DEPTH.
//  After last compare -> DRAIN; DATA_I_CPU holds last stimulus.
//  DRAIN: wait CAR_ZERO==1 (checked from first DRAIN cycle); else after TIMEOUT cycles set TIMEOUT_ERR -> REPORT.
//  REPORT: 1 cycle, DONE=1, PASS computed; -> IDLE, BUSY=0.
//  Counters saturate at 2^CNT_W-1. LOAD_EN and START while BUSY ignored. LOAD_EN and START same
//   cycle in IDLE: write takes effect, run uses new vector.
// STRUCTURE
//  Package cpu_tb_pkg: state enum (IDLE,RSTP,WARM,RUN,DRAIN,REPORT), default DATA_W/DEPTH constants.
//  Sub-module vec_store: DEPTH x (3*DATA_W) register file, sync write, async read by idx.
//  Top: FSM, idx counter, timeout counter, compare/count/first-fail logic.
// TESTING  (CPU stub: DATA_O_CPU = DATA_I_CPU combinational, CAR_ZERO=1 unless stated)
//  Load 7 vectors stim=exp {4,2,7,5,5,5,1}, mask FFFF, START -> PASS_CNT=7, FAIL_CNT=0, PASS=1, DONE 1 cycle.
//  Vector 3 exp=0002 (stim 0005), mask FFFF -> FAIL_CNT=1, FF_IDX=3, FF_GOT=0005, PASS=0.
//  Same vector with mask FFF0 -> counted pass; mask 000F -> fail.
//  CAR_ZERO held 0, TIMEOUT=255 -> DONE exactly 256 cycles after DRAIN entry... TIMEOUT_ERR=1, PASS=0.
//  RST low during RUN at vector 2 -> next cycle IDLE, BUSY=0, counters 0, no DONE; rerun without reload passes.
//  NUM_VEC=0 -> CPU_RST_N low 1 cycle, DONE after RSTP+WARM+DRAIN, PASS=1, counters 0; START while BUSY no effect.

Source files
------------

// File: rtl/cpu_vector_checker_pkg.sv
// Shared types and default sizes for the CPU vector player/checker.
package cpu_vector_checker_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int DEPTH_DEF   = 16;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 255;

  // Run sequence: reset pulse, warm-up, play vectors, wait for CAR==0, report.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RSTP   = 3'd1,
    WARM   = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4,
    REPORT = 3'd5
  } state_t;

endpackage

// File: rtl/cpu_vector_checker_vec_store.sv
// Vector register file: DEPTH entries of {stimulus, expected, mask}.
// Synchronous write, asynchronous read. Contents survive reset on purpose
// so a run can be repeated without reloading.
module cpu_vector_checker_vec_store #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_stim,
  input  logic [DATA_W-1:0] wr_exp,
  input  logic [DATA_W-1:0] wr_mask,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_stim,
  output logic [DATA_W-1:0] rd_exp,
  output logic [DATA_W-1:0] rd_mask
);

  logic [3*DATA_W-1:0] mem [DEPTH];
  logic [3*DATA_W-1:0] rd_word;

  // Write one slot; out-of-range indices (non power-of-two DEPTH) are dropped.
  always_ff @(posedge CLK) begin
    if (we && (32'(wr_idx) < DEPTH)) begin
      mem[wr_idx] <= {wr_stim, wr_exp, wr_mask};
    end
  end

  // Combinational read; out-of-range indices read as zero.
  always_comb begin
    rd_word = '0;
    if (32'(rd_idx) < DEPTH) begin
      rd_word = mem[rd_idx];
    end
  end

  assign rd_stim = rd_word[3*DATA_W-1:2*DATA_W];
  assign rd_exp  = rd_word[2*DATA_W-1:DATA_W];
  assign rd_mask = rd_word[DATA_W-1:0];

endmodule

// File: rtl/cpu_vector_checker.sv
// Vector player/checker for the microsequenced CPU: pulses the CPU reset,
// plays one stored stimulus word per cycle, compares the CPU output under
// mask, waits for CAR==0 and reports pass/fail counts plus first failure.
//
// Handshake: START and LOAD_EN are single-cycle requests accepted only while
// the FSM is IDLE (BUSY==0); DONE is a one-cycle pulse and the result outputs
// stay valid from DONE until the next accepted START.
module cpu_vector_checker
  import cpu_vector_checker_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD_EN,
  input  logic [IDX_W-1:0]  LOAD_IDX,
  input  logic [DATA_W-1:0] LOAD_STIM,
  input  logic [DATA_W-1:0] LOAD_EXP,
  input  logic [DATA_W-1:0] LOAD_MASK,
  input  logic [IDX_W:0]    NUM_VEC,
  input  logic              START,
  input  logic              CAR_ZERO,
  input  logic [DATA_W-1:0] DATA_O_CPU,
  output logic [DATA_W-1:0] DATA_I_CPU,
  output logic              CPU_RST_N,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [CNT_W-1:0]  PASS_CNT,
  output logic [CNT_W-1:0]  FAIL_CNT,
  output logic              FF_VALID,
  output logic [IDX_W-1:0]  FF_IDX,
  output logic [DATA_W-1:0] FF_GOT,
  output logic              TIMEOUT_ERR,
  output logic [2:0]        DBG_STATE
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [IDX_W:0]   DEPTH_V = (IDX_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nx;
  logic [IDX_W:0]    nvec;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              warm_cnt;
  logic [TO_W-1:0]   tcnt;
  logic [DATA_W-1:0] exp_r, mask_r;
  logic [DATA_W-1:0] rd_stim, rd_exp, rd_mask;
  logic [IDX_W:0]    nvec_clamp;
  logic              last_vec;
  logic              match;
  logic              drain_exit;

  // In RUN the store is read one slot ahead so the next stimulus is ready
  // at the same edge that compares the current one.
  assign rd_idx     = (state == RUN) ? (idx + IDX_W'(1)) : '0;
  assign nvec_clamp = (NUM_VEC > DEPTH_V) ? DEPTH_V : NUM_VEC;
  assign last_vec   = (({1'b0, idx} + (IDX_W + 1)'(1)) == nvec);
  assign match      = (((DATA_O_CPU ^ exp_r) & mask_r) == '0);
  assign drain_exit = CAR_ZERO || (tcnt == TO_MAX);

  cpu_vector_checker_vec_store #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_store (
    .CLK     (CLK),
    .we      (LOAD_EN && (state == IDLE)),
    .wr_idx  (LOAD_IDX),
    .wr_stim (LOAD_STIM),
    .wr_exp  (LOAD_EXP),
    .wr_mask (LOAD_MASK),
    .rd_idx  (rd_idx),
    .rd_stim (rd_stim),
    .rd_exp  (rd_exp),
    .rd_mask (rd_mask)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nx  = state;
    BUSY      = (state != IDLE);
    DONE      = (state == REPORT);
    CPU_RST_N = (state != RSTP);
    DBG_STATE = state;
    case (state)
      IDLE:    if (START) state_nx = RSTP;
      RSTP:    state_nx = WARM;
      WARM:    if (warm_cnt) state_nx = (nvec == '0) ? DRAIN : RUN;
      RUN:     if (last_vec) state_nx = DRAIN;
      DRAIN:   if (drain_exit) state_nx = REPORT;
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: vector sequencing, compare, saturating counts, first failure.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      nvec        <= '0;
      idx         <= '0;
      warm_cnt    <= 1'b0;
      tcnt        <= '0;
      exp_r       <= '0;
      mask_r      <= '0;
      DATA_I_CPU  <= '0;
      PASS        <= 1'b0;
      PASS_CNT    <= '0;
      FAIL_CNT    <= '0;
      FF_VALID    <= 1'b0;
      FF_IDX      <= '0;
      FF_GOT      <= '0;
      TIMEOUT_ERR <= 1'b0;
    end else begin
      if (state != DRAIN) tcnt <= '0;
      case (state)
        IDLE: begin
          if (START) begin
            nvec        <= nvec_clamp;
            PASS        <= 1'b0;
            PASS_CNT    <= '0;
            FAIL_CNT    <= '0;
            FF_VALID    <= 1'b0;
            FF_IDX      <= '0;
            FF_GOT      <= '0;
            TIMEOUT_ERR <= 1'b0;
          end
        end
        RSTP: warm_cnt <= 1'b0;
        WARM: begin
          warm_cnt <= 1'b1;
          if (warm_cnt && (nvec != '0)) begin
            idx        <= '0;
            DATA_I_CPU <= rd_stim;
            exp_r      <= rd_exp;
            mask_r     <= rd_mask;
          end
        end
        RUN: begin
          if (match) begin
            if (PASS_CNT != CNT_MAX) PASS_CNT <= PASS_CNT + CNT_W'(1);
          end else begin
            if (FAIL_CNT != CNT_MAX) FAIL_CNT <= FAIL_CNT + CNT_W'(1);
            if (!FF_VALID) begin
              FF_VALID <= 1'b1;
              FF_IDX   <= idx;
              FF_GOT   <= DATA_O_CPU;
            end
          end
          if (!last_vec) begin
            idx        <= idx + IDX_W'(1);
            DATA_I_CPU <= rd_stim;
            exp_r      <= rd_exp;
            mask_r     <= rd_mask;
          end
        end
        DRAIN: begin
          tcnt <= tcnt + TO_W'(1);
          if (drain_exit) begin
            TIMEOUT_ERR <= !CAR_ZERO;
            PASS        <= (FAIL_CNT == '0) && CAR_ZERO;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_vector_checker.sv
// Randomized and directed bench for cpu_vector_checker with a loopback CPU stub.
module tb_cpu_vector_checker;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 255;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              CLK, RST;
  logic              LOAD_EN;
  logic [IDX_W-1:0]  LOAD_IDX;
  logic [DATA_W-1:0] LOAD_STIM, LOAD_EXP, LOAD_MASK;
  logic [IDX_W:0]    NUM_VEC;
  logic              START, CAR_ZERO;
  logic [DATA_W-1:0] DATA_O_CPU, DATA_I_CPU;
  logic              CPU_RST_N, BUSY, DONE, PASS;
  logic [CNT_W-1:0]  PASS_CNT, FAIL_CNT;
  logic              FF_VALID;
  logic [IDX_W-1:0]  FF_IDX;
  logic [DATA_W-1:0] FF_GOT;
  logic              TIMEOUT_ERR;
  logic [2:0]        DBG_STATE;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] m_stim [DEPTH];
  logic [DATA_W-1:0] m_exp  [DEPTH];
  logic [DATA_W-1:0] m_mask [DEPTH];
  logic [DATA_W-1:0] exp_q[$];

  // CPU stub: output follows input combinationally.
  assign DATA_O_CPU = DATA_I_CPU;

  cpu_vector_checker #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .IDX_W (IDX_W), .CNT_W (CNT_W), .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK (CLK), .RST (RST), .LOAD_EN (LOAD_EN), .LOAD_IDX (LOAD_IDX),
    .LOAD_STIM (LOAD_STIM), .LOAD_EXP (LOAD_EXP), .LOAD_MASK (LOAD_MASK),
    .NUM_VEC (NUM_VEC), .START (START), .CAR_ZERO (CAR_ZERO),
    .DATA_O_CPU (DATA_O_CPU), .DATA_I_CPU (DATA_I_CPU), .CPU_RST_N (CPU_RST_N),
    .BUSY (BUSY), .DONE (DONE), .PASS (PASS), .PASS_CNT (PASS_CNT),
    .FAIL_CNT (FAIL_CNT), .FF_VALID (FF_VALID), .FF_IDX (FF_IDX), .FF_GOT (FF_GOT),
    .TIMEOUT_ERR (TIMEOUT_ERR), .DBG_STATE (DBG_STATE)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver: present a load without advancing time (model updated too).
  task automatic set_load(input int i, input logic [DATA_W-1:0] s,
                          input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] m);
    LOAD_EN = 1'b1; LOAD_IDX = IDX_W'(i); LOAD_STIM = s; LOAD_EXP = e; LOAD_MASK = m;
    m_stim[i] = s; m_exp[i] = e; m_mask[i] = m;
  endtask

  task automatic load_vec(input int i, input logic [DATA_W-1:0] s,
                          input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] m);
    set_load(i, s, e, m);
    @(negedge CLK);
    LOAD_EN = 1'b0;
  endtask

  // Driver + scoreboard for one run. car_delay<0 holds CAR_ZERO low;
  // abort_at>=0 pulls RST low during that cycle after START.
  task automatic run_vec(input int nv, input int car_delay, input int abort_at);
    int nc, ep, ef, ecyc, effi, cyc;
    bit eto, effv, seen_done;
    logic [DATA_W-1:0] effg;
    nc = (nv > DEPTH) ? DEPTH : nv;
    ep = 0; ef = 0; effv = 0; effi = 0; effg = '0;
    exp_q.delete();
    for (int k = 0; k < nc; k++) begin
      exp_q.push_back(m_stim[k]);
      if (((m_stim[k] ^ m_exp[k]) & m_mask[k]) == '0) ep++;
      else begin
        ef++;
        if (!effv) begin effv = 1; effi = k; effg = m_stim[k]; end
      end
    end
    if (ep > CNT_MAX) ep = CNT_MAX;
    if (ef > CNT_MAX) ef = CNT_MAX;
    eto  = (car_delay < 0) || (car_delay > TIMEOUT);
    ecyc = eto ? (4 + nc + TIMEOUT) : (4 + nc + car_delay);
    NUM_VEC = (IDX_W + 1)'(nv);
    START = 1'b1;
    CAR_ZERO = 1'b0;
    seen_done = 0;
    for (cyc = 0; cyc < 700 && !seen_done; cyc++) begin
      @(negedge CLK);
      if (cyc == 0) begin START = 1'b0; LOAD_EN = 1'b0; end
      if (cyc == 1) begin
        START = 1'b1; NUM_VEC = '1; LOAD_EN = 1'b1;
        LOAD_IDX = IDX_W'($urandom_range(0, DEPTH - 1));
        LOAD_STIM = DATA_W'($urandom); LOAD_EXP = DATA_W'($urandom); LOAD_MASK = '1;
      end
      if (cyc == 2) begin START = 1'b0; LOAD_EN = 1'b0; end
      if (cyc == abort_at) begin
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        check("abort_busy", BUSY, 0);
        check("abort_done", DONE, 0);
        check("abort_pass_cnt", PASS_CNT, 0);
        check("abort_fail_cnt", FAIL_CNT, 0);
        check("abort_cpu_rst_n", CPU_RST_N, 1);
        check("abort_data_i", DATA_I_CPU, 0);
        repeat (4) begin
          @(negedge CLK);
          check("abort_no_done", DONE, 0);
        end
        return;
      end
      check("busy", BUSY, 1);
      check("cpu_rst_n", CPU_RST_N, (cyc != 0));
      if (cyc >= 3 && cyc < 3 + nc) check("data_i_run", DATA_I_CPU, exp_q.pop_front());
      if (cyc >= 3 + nc && nc > 0) check("data_i_hold", DATA_I_CPU, m_stim[nc-1]);
      if (DONE) begin
        seen_done = 1;
        check("done_cycle", cyc, ecyc);
        check("pass_cnt", PASS_CNT, ep);
        check("fail_cnt", FAIL_CNT, ef);
        check("pass", PASS, (ef == 0) && !eto);
        check("timeout_err", TIMEOUT_ERR, eto);
        check("ff_valid", FF_VALID, effv);
        check("ff_idx", FF_IDX, effi);
        check("ff_got", FF_GOT, effg);
      end
      CAR_ZERO = (car_delay >= 0) && (cyc >= 3 + nc + car_delay);
    end
    if (!seen_done) check("done_seen", 0, 1);
    @(negedge CLK);
    check("done_pulse_end", DONE, 0);
    check("idle_busy", BUSY, 0);
    check("pass_held", PASS, (ef == 0) && !eto);
    CAR_ZERO = 1'b1;
  endtask

  initial begin
    int vals[7];
    RST = 1'b0; LOAD_EN = 1'b0; LOAD_IDX = '0; LOAD_STIM = '0; LOAD_EXP = '0;
    LOAD_MASK = '0; NUM_VEC = '0; START = 1'b0; CAR_ZERO = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_data_i", DATA_I_CPU, 0);
    check("rst_cpu_rst_n", CPU_RST_N, 1);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_pass", PASS, 0);
    check("rst_cnts", {PASS_CNT, FAIL_CNT}, 0);
    check("rst_ff", {FF_VALID, FF_IDX, FF_GOT}, 0);
    check("rst_timeout", TIMEOUT_ERR, 0);
    RST = 1'b1;
    @(negedge CLK);

    vals = '{4, 2, 7, 5, 5, 5, 1};
    for (int i = 0; i < 7; i++) load_vec(i, DATA_W'(vals[i]), DATA_W'(vals[i]), 16'hFFFF);
    run_vec(7, 0, -1);
    load_vec(3, 16'h0005, 16'h0002, 16'hFFFF);
    run_vec(7, 0, -1);
    load_vec(3, 16'h0005, 16'h0002, 16'h000F);
    run_vec(7, 0, -1);
    load_vec(3, 16'h0005, 16'h0002, 16'hFFF0);
    run_vec(7, 0, -1);
    run_vec(7, -1, -1);
    run_vec(7, 0, 5);
    run_vec(7, 0, -1);
    run_vec(0, 0, -1);
    set_load(0, 16'h1234, 16'h9999, 16'hFFFF);
    run_vec(3, 2, -1);

    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [DATA_W-1:0] s, e, m;
        s = DATA_W'($urandom);
        e = ($urandom_range(0, 3) == 0) ? (s ^ DATA_W'($urandom)) : s;
        m = ($urandom_range(0, 1) == 0) ? 16'hFFFF : DATA_W'($urandom);
        load_vec(i, s, e, m);
      end
      run_vec($urandom_range(0, 31), $urandom_range(0, 12), -1);
    end
    run_vec(DEPTH, 300, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
